// File: rtl/truth_table_scanner_pkg.sv
// Shared types, sizes and helpers for the truth-table scanner.
package truth_table_scanner_pkg;

  localparam int unsigned NUM_VECTORS = 16;
  localparam int unsigned IDX_W       = 4;

  // Y = A*(B+C) + A*C*D reduces to A*(B+C): ones at vectors 10..15.
  localparam logic [NUM_VECTORS-1:0] GOLDEN_TT = 16'hFC00;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSettle,
    StSample,
    StDone
  } state_e;

  // Number of set bits in a 16-bit word (0..16).
  function automatic logic [4:0] popcount16(input logic [NUM_VECTORS-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NUM_VECTORS; i++) begin
      n = n + {4'b0, v[i]};
    end
    return n;
  endfunction

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [IDX_W-1:0] lowest_set_idx(input logic [NUM_VECTORS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/truth_table_scanner_bool_eval_core.sv
// Pure combinational evaluator for Y = A*(B+C) + A*C*D, vec = {A,B,C,D}.
module bool_eval_core (
  input  logic [3:0] vec,
  output logic       y
);

  logic a, b, c, d;

  // Unpack the vector with A as the MSB.
  always_comb begin
    {a, b, c, d} = vec;
    y = (a & (b | c)) | (a & c & d);
  end

endmodule

// File: rtl/truth_table_scanner.sv
// Walks all 16 input vectors through the evaluator, captures the truth
// table and compares it against a caller-supplied expected mask.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NUM_VECTORS-1:0] expected,
  output logic [IDX_W-1:0]       vec_out,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_VECTORS-1:0] table_out,
  output logic                   pass,
  output logic [4:0]             mismatch_count,
  output logic [IDX_W-1:0]       first_fail_idx
);

  localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);
  localparam bit         HasSettle  = (SETTLE_CYCLES != 0);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [3:0]             settle_q, settle_d;
  logic [NUM_VECTORS-1:0] shadow_q, shadow_d;
  logic [NUM_VECTORS-1:0] exp_q, exp_d;
  logic [NUM_VECTORS-1:0] table_q;
  logic                   pass_q;
  logic [4:0]             mm_q;
  logic [IDX_W-1:0]       ffi_q;
  logic                   commit;
  logic                   y;
  logic [NUM_VECTORS-1:0] diff;

  // The scanner is the only driver of the evaluator inputs.
  bool_eval_core u_eval (
    .vec (idx_q),
    .y   (y)
  );

  // Next-state, index, settle countdown and shadow capture.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    shadow_d = shadow_q;
    exp_d    = exp_q;
    commit   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StApply;
          idx_d   = '0;
          exp_d   = expected;
        end
      end
      StApply: begin
        settle_d = SettleInit;
        state_d  = HasSettle ? StSettle : StSample;
      end
      StSettle: begin
        if (settle_q <= 4'd1) begin
          settle_d = '0;
          state_d  = StSample;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      StSample: begin
        shadow_d[idx_q] = y;
        // Last vector goes to DONE instead of wrapping the index.
        if (idx_q == IDX_W'(NUM_VECTORS - 1)) begin
          state_d = StDone;
          commit  = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StApply;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Abort overrides everything outside IDLE; an aborted scan commits nothing.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      commit  = 1'b0;
    end
  end

  // Compare the completed table (including the bit captured this cycle).
  always_comb begin
    diff = shadow_d ^ exp_q;
  end

  // Controller state, index, settle counter, shadow and expected registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      settle_q <= '0;
      shadow_q <= '0;
      exp_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      shadow_q <= shadow_d;
      exp_q    <= exp_d;
    end
  end

  // Results load on the edge into DONE so they are valid alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      table_q <= '0;
      pass_q  <= 1'b0;
      mm_q    <= '0;
      ffi_q   <= '0;
    end else if (commit) begin
      table_q <= shadow_d;
      pass_q  <= (diff == '0);
      mm_q    <= popcount16(diff);
      ffi_q   <= lowest_set_idx(diff);
    end
  end

  assign vec_out        = idx_q;
  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StDone);
  assign table_out      = table_q;
  assign pass           = pass_q;
  assign mismatch_count = mm_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed, table-driven bench for truth_table_scanner (settle 1 and settle 0 builds).
module tb_truth_table_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1, abort0, abort1;
  logic [15:0] exp0, exp1;
  logic [3:0]  vec0, vec1, ffi0, ffi1;
  logic        busy0, busy1, done0, done1, pass0, pass1;
  logic [15:0] tab0, tab1;
  logic [4:0]  mm0, mm1;

  bit          sel0;  // 1: talk to the SETTLE_CYCLES=0 instance
  logic [3:0]  m_vec, m_ffi;
  logic        m_busy, m_done, m_pass;
  logic [15:0] m_tab;
  logic [4:0]  m_mm;

  int n_checks = 0;
  int n_errors = 0;

  truth_table_scanner #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(exp1),
    .vec_out(vec1), .busy(busy1), .done(done1), .table_out(tab1), .pass(pass1),
    .mismatch_count(mm1), .first_fail_idx(ffi1)
  );

  truth_table_scanner #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .expected(exp0),
    .vec_out(vec0), .busy(busy0), .done(done0), .table_out(tab0), .pass(pass0),
    .mismatch_count(mm0), .first_fail_idx(ffi0)
  );

  assign m_vec  = sel0 ? vec0  : vec1;
  assign m_ffi  = sel0 ? ffi0  : ffi1;
  assign m_busy = sel0 ? busy0 : busy1;
  assign m_done = sel0 ? done0 : done1;
  assign m_pass = sel0 ? pass0 : pass1;
  assign m_tab  = sel0 ? tab0  : tab1;
  assign m_mm   = sel0 ? mm0   : mm1;

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] e;
    logic        p;
    logic [4:0]  mm;
    logic [3:0]  ffi;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic ab, input logic [15:0] e);
    if (sel0) begin
      start0 = st; abort0 = ab; exp0 = e;
    end else begin
      start1 = st; abort1 = ab; exp1 = e;
    end
  endtask

  task automatic check_results(input string tag, input logic [15:0] tab, input logic p,
                               input logic [4:0] mm, input logic [3:0] ffi);
    check({tag, "_table"}, m_tab, tab);
    check({tag, "_pass"}, m_pass, p);
    check({tag, "_mm"}, m_mm, mm);
    check({tag, "_ffi"}, m_ffi, ffi);
  endtask

  // Start a scan and run until done; leaves the bench in the DONE cycle.
  task automatic run_scan(input logic [15:0] e, output int done_cyc);
    int per, tgt, c;
    per = sel0 ? 2 : 3;
    tgt = 16 * per + 1;
    drive(1'b1, 1'b0, e);
    done_cyc = -1;
    c = 0;
    while (done_cyc < 0 && c < tgt + 8) begin
      tick();
      c++;
      if (c == 1) begin
        drive(1'b0, 1'b0, e);
        check("busy_rise", m_busy, 1);
      end
      if (m_done) done_cyc = c;
      else if (c < tgt) check("vec_out", m_vec, 32'((c - 1) / per));
    end
    check("done_cycle", done_cyc, tgt);
    check("busy_in_done", m_busy, 1);
  endtask

  task automatic end_pulse();
    tick();
    check("done_pulse_end", m_done, 0);
    check("busy_fall", m_busy, 0);
  endtask

  initial begin
    int dc, nd, c;
    vecs[0] = '{16'hFC00, 1'b1, 5'd0,  4'd0};
    vecs[1] = '{16'hFC01, 1'b0, 5'd1,  4'd0};
    vecs[2] = '{16'h0000, 1'b0, 5'd6,  4'd10};
    vecs[3] = '{16'hFFFF, 1'b0, 5'd10, 4'd0};
    vecs[4] = '{16'h03FF, 1'b0, 5'd16, 4'd0};
    vecs[5] = '{16'h8C00, 1'b0, 5'd3,  4'd12};
    vecs[6] = '{16'hFE00, 1'b0, 5'd1,  4'd9};

    rst_n = 1'b0;
    start0 = 0; start1 = 0; abort0 = 0; abort1 = 0; exp0 = '0; exp1 = '0;
    sel0 = 1'b0;
    repeat (2) tick();
    check("reset_busy", m_busy, 0);
    check("reset_done", m_done, 0);
    check("reset_vec", m_vec, 0);
    check_results("reset", 16'h0, 1'b0, 5'd0, 4'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven scans on the SETTLE_CYCLES=1 instance.
    for (int i = 0; i < 7; i++) begin
      run_scan(vecs[i].e, dc);
      check_results("vec", 16'hFC00, vecs[i].p, vecs[i].mm, vecs[i].ffi);
      end_pulse();
    end

    // Abort at cycle 20: no done, previous results (FE00 scan) untouched.
    drive(1'b1, 1'b0, 16'hFC00);
    for (c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) drive(1'b0, 1'b0, 16'hFC00);
    end
    drive(1'b0, 1'b1, 16'hFC00);
    tick();
    drive(1'b0, 1'b0, 16'hFC00);
    check("abort_busy", m_busy, 0);
    check("abort_done", m_done, 0);
    nd = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (m_done || m_busy) nd++;
    end
    check("abort_no_activity", nd, 0);
    check_results("abort", 16'hFC00, 1'b0, 5'd1, 4'd9);

    // Repeated start while busy: one scan, expected from the accepted start only.
    drive(1'b1, 1'b0, 16'hFC01);
    nd = 0;
    dc = -1;
    for (c = 1; c <= 49 + 40; c++) begin
      tick();
      if (c < 49) drive((c % 4) == 0, 1'b0, 16'h0000);
      else drive(1'b0, 1'b0, 16'h0000);
      if (m_done) begin
        nd++;
        if (dc < 0) dc = c;
      end
    end
    check("busy_start_done_count", nd, 1);
    check("busy_start_done_cycle", dc, 49);
    check("busy_start_idle", m_busy, 0);
    check_results("busy_start", 16'hFC00, 1'b0, 5'd1, 4'd0);

    // start and abort together in IDLE: no scan.
    drive(1'b1, 1'b1, 16'hFC00);
    tick();
    drive(1'b0, 1'b0, 16'hFC00);
    check("start_abort_busy", m_busy, 0);
    nd = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (m_done || m_busy) nd++;
    end
    check("start_abort_no_scan", nd, 0);
    check("start_abort_pass", m_pass, 0);

    // Reset mid-scan at vector 7.
    drive(1'b1, 1'b0, 16'hFC00);
    for (c = 1; c <= 22; c++) begin
      tick();
      if (c == 1) drive(1'b0, 1'b0, 16'hFC00);
    end
    check("pre_reset_vec", m_vec, 7);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", m_busy, 0);
    check("midreset_vec", m_vec, 0);
    check_results("midreset", 16'h0, 1'b0, 5'd0, 4'd0);
    tick();
    check("midreset_busy2", m_busy, 0);
    check("midreset_table2", m_tab, 0);
    rst_n = 1'b1;
    tick();
    run_scan(16'hFC00, dc);
    check_results("post_reset", 16'hFC00, 1'b1, 5'd0, 4'd0);
    end_pulse();

    // SETTLE_CYCLES=0 instance, with a back-to-back second scan.
    sel0 = 1'b1;
    run_scan(16'hFC00, dc);
    check_results("s0_first", 16'hFC00, 1'b1, 5'd0, 4'd0);
    end_pulse();
    run_scan(16'h0000, dc);
    check_results("s0_b2b", 16'hFC00, 1'b0, 5'd6, 4'd10);
    end_pulse();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
